// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add.sv
// 4-bit ripple-carry adder slice, time-shared across all nibbles of an operation.
module nibble_add
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    // NOTE: blocking assignments here are deliberate; c must ripple bit to bit within one evaluation.
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds or subtracts two DATA_W operands one nibble per cycle through a single shared
// 4-bit adder slice; results are registered on entry to DONE and held until the next one.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NIB_N  = DATA_W / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_cout,
  output logic              out_ovf,
  output logic              out_zero,
  output logic              busy
);

  localparam int IDX_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB_N - 1);

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic [DATA_W-1:0] a_sh, b_sh, res_sh, res_nx;
  logic [NIBBLE_W-1:0] slice_sum;
  logic              slice_cout;
  logic              accept, last;

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign last      = (idx == LAST_IDX);

  // Operands shift down so the active nibble always sits in the low slice;
  // the result shifts in from the top and is complete after NIB_N steps.
  nibble_add u_slice (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign res_nx = {slice_sum, res_sh[DATA_W-1:NIBBLE_W]};

  // NOTE: non-blocking assignments for every register so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= in_a;
            b_sh  <= in_sub ? ~in_b : in_b;
            carry <= in_sub;
            idx   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> NIBBLE_W;
          b_sh   <= b_sh >> NIBBLE_W;
          res_sh <= res_nx;
          carry  <= slice_cout;
          idx    <= idx + IDX_W'(1);
          if (last) begin
            // On the last step the low slice holds the MSB nibble of A and Bop.
            out_sum  <= res_nx;
            out_cout <= slice_cout;
            out_ovf  <= (a_sh[NIBBLE_W-1] == b_sh[NIBBLE_W-1]) &&
                        (slice_sum[NIBBLE_W-1] != a_sh[NIBBLE_W-1]);
            out_zero <= (res_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench: directed vector table, corner-case sequences and random
// operations compared against an arithmetic reference model.
module tb_nibble_serial_add_ctrl;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_sub;
  logic [DATA_W-1:0] in_a, in_b;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_cout, out_ovf, out_zero, busy;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] prev_sum;

  nibble_serial_add_ctrl #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sub;
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              ovf;
    logic              zero;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, independent of slicing.
  function automatic void model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                input logic sub, output logic [DATA_W-1:0] sum,
                                output logic c, output logic o, output logic z);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      sum = a - b;
      c   = (a >= b);
      r   = sa - sb;
    end else begin
      sum = a + b;
      c   = ({1'b0, a} + {1'b0, b}) > 17'h0FFFF;
      r   = sa + sb;
    end
    o = (r > 32767) || (r < -32768);
    z = (sum == '0);
  endfunction

  // Issue one request, scramble inputs during RUN, wait for DONE, capture, handshake.
  task automatic do_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic sub, input string tag,
                       output logic [DATA_W-1:0] s, output logic c,
                       output logic o, output logic z);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
    tick();
    in_valid = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom_range(1));
    check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    check({tag, " hold_in_run"}, 32'(out_sum), 32'(prev_sum));
    n = 0;
    while (!out_valid && n < 20) begin
      tick(); n++;
      in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom_range(1));
    end
    check({tag, " latency"}, 32'(n), 32'd4);
    s = out_sum; c = out_cout; o = out_ovf; z = out_zero;
    prev_sum = out_sum;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " idle_after_handshake"}, 32'({out_valid, busy, in_ready}), 32'b001);
  endtask

  initial begin
    vec_t vecs[6];
    logic [DATA_W-1:0] s, es, hold;
    logic c, o, z, ec, eo, ez;
    logic [DATA_W-1:0] ra, rb;
    logic rs;
    logic saw_valid;

    vecs[0] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    prev_sum = '0;

    // Reset for 3 cycles.
    rst = 1'b1;
    #1;
    check("in_ready_during_reset", 32'(in_ready), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_sum", 32'(out_sum), 32'h0000);
    check("reset busy", 32'(busy), 32'd0);
    check("reset flags", 32'({out_cout, out_ovf, out_zero}), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, $sformatf("vec%0d", i), s, c, o, z);
      check($sformatf("vec%0d sum", i), 32'(s), 32'(vecs[i].sum));
      check($sformatf("vec%0d cout", i), 32'(c), 32'(vecs[i].cout));
      check($sformatf("vec%0d ovf", i), 32'(o), 32'(vecs[i].ovf));
      check($sformatf("vec%0d zero", i), 32'(z), 32'(vecs[i].zero));
    end

    // Back-pressure: hold out_ready low in DONE with a pending request.
    in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_sub = 1'b0;
    tick();
    in_a = 16'hAAAA; in_b = 16'h5555; in_sub = 1'b1;
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      check("bp latency", 32'(n), 32'd4);
    end
    hold = out_sum;
    check("bp sum", 32'(hold), 32'h3333);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp%0d stable", i), 32'(out_sum), 32'(hold));
      check($sformatf("bp%0d hs", i), 32'({out_valid, in_ready, busy}), 32'b101);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("bp release idle", 32'({out_valid, busy, in_ready}), 32'b001);
    check("bp release sum held", 32'(out_sum), 32'h3333);
    prev_sum = out_sum;

    // Reset after two RUN cycles of 0x00FF + 0x0001.
    in_valid = 1'b1; in_a = 16'h00FF; in_b = 16'h0001; in_sub = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("midrst out_sum", 32'(out_sum), 32'h0000);
    check("midrst status", 32'({out_valid, busy, in_ready}), 32'b000);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rst = 1'b0;
      tick();
      saw_valid |= out_valid;
    end
    check("midrst no valid pulse", 32'(saw_valid), 32'd0);
    check("midrst out_sum after", 32'(out_sum), 32'h0000);
    prev_sum = '0;
    do_op(16'h0002, 16'h0003, 1'b0, "post_rst", s, c, o, z);
    check("post_rst sum", 32'(s), 32'h0005);

    // Randomized operations against the model, biased toward edge values.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(3))
        0:       ra = 16'h8000;
        1:       ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(4) == 0) ? ra : 16'($urandom);
      rs = 1'($urandom_range(1));
      model(ra, rb, rs, es, ec, eo, ez);
      do_op(ra, rb, rs, $sformatf("rnd%0d", i), s, c, o, z);
      check($sformatf("rnd%0d flags_sum", i), {12'd0, c, o, z, 1'b0, s},
            {12'd0, ec, eo, ez, 1'b0, es});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
